alu_issue_arbiter: RTL
======================

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 Parameters SHALL be:
  - NUM_REQ, 4, requester count.
  - DATA_W, 32, operand/result width.
  - TAG_W, 5, destination tag width.
  - OP_W, 6, opcode width.
  - TIMEOUT_CYC, 16, watchdog limit.
REQ-002 Ports SHALL be:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - req_valid  in  NUM_REQ  requester i has an operation pending.
  - req_opcode  in  NUM_REQ*OP_W  packed opcodes, slice i = requester i.
  - req_op1, req_op2  in  NUM_REQ*DATA_W  packed operands.
  - req_tag  in  NUM_REQ*TAG_W  packed destination tags.
  - req_ack  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
  - alu_start  out  1  ALU launch pulse.
  - alu_opcode  out  OP_W  to ALU.
  - alu_op1, alu_op2  out  DATA_W  to ALU.
  - alu_dest_tag  out  TAG_W  to ALU.
  - alu_done  in  1  ALU completion pulse.
  - alu_out_tag  in  TAG_W  from ALU.
  - alu_result  in  DATA_W  from ALU.
  - cdb_valid  out  1  broadcast valid.
  - cdb_ready  in  1  bus accepts.
  - cdb_tag  out  TAG_W  broadcast tag.
  - cdb_data  out  DATA_W  broadcast data.
  - busy  out  1  FSM not IDLE.
  - err_timeout  out  1  sticky watchdog flag (macro only).

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and BCAST.
REQ-004 IDLE: if any req_valid is high, the block SHALL grant round-robin, searching from rr_ptr upward with wrap.
  - On grant it SHALL pulse req_ack[g], latch opcode/op1/op2/tag of g, and go to ISSUE.
REQ-005 ISSUE: alu_start SHALL be high for exactly one cycle with the latched fields on alu_*, then the FSM SHALL go to WAIT.
REQ-006 alu_* data outputs SHALL hold the latched values from ISSUE until alu_done.
REQ-007 WAIT: alu_done SHALL be sampled only in WAIT.
  - On alu_done, alu_result and alu_out_tag SHALL be captured into a holding register and the FSM SHALL go to BCAST.
  - alu_done in any other state SHALL be ignored.
REQ-008 BCAST: cdb_valid SHALL be high with stable cdb_tag/cdb_data until the cycle cdb_ready is high.
  - In that cycle rr_ptr SHALL become (g+1) mod NUM_REQ and the FSM SHALL go to IDLE.
REQ-009 Minimum request-to-request spacing SHALL be: ack at cycle 0, alu_start at 1, alu_done at 2 or later, cdb handshake at 3 or later, next ack at 4 or later.
REQ-010 A requester deasserting req_valid before grant SHALL simply lose arbitration; no state SHALL be retained for it.
REQ-011 cdb_ready asserted outside BCAST SHALL have no effect.
REQ-012 busy SHALL equal (state != IDLE).

Reset
REQ-013 rst SHALL asynchronously force the following, aborting any in-flight operation without broadcast:
  - state=IDLE, rr_ptr=0.
  - req_ack=0, alu_start=0, cdb_valid=0.
  - alu_*, cdb_tag, cdb_data and holding registers = 0.
  - err_timeout=0.
REQ-014 A result returning after reset deassertion SHALL be ignored, since the FSM is in IDLE.

Configuration
REQ-015 With ALU_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL operate.
  - If alu_done is absent for TIMEOUT_CYC cycles in WAIT, err_timeout SHALL set (sticky until rst) and the FSM SHALL return to IDLE without broadcast, advancing rr_ptr.
REQ-016 Without ALU_ARB_TIMEOUT_EN, there SHALL be no counter, err_timeout SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-017 Shared package alu_pkg SHALL hold OP_W, DATA_W, TAG_W and the FSM state enum (IDLE, ISSUE, WAIT, BCAST).
REQ-018 Round-robin selection SHALL be the sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant and index).

Verification
REQ-019 Single request: req_valid=4'b0001, opcode 0, op1=5, op2=7, tag=5'h0A; ALU returns 12, tag 0A.
  -> req_ack[0] at cycle 0, alu_start at cycle 1, cdb_valid with tag 0A / data 12 after alu_done.
REQ-020 Fairness: all four req_valid held high continuously.
  -> grants in order 0,1,2,3,0, one per transaction.
REQ-021 CDB backpressure: cdb_ready low for 5 cycles in BCAST.
  -> cdb_valid/tag/data stable throughout; no new req_ack until the handshake.
REQ-022 Reset mid-WAIT: assert rst, then alu_done arrives afterwards.
  -> all outputs 0 immediately; no cdb_valid; rr_ptr=0.
REQ-023 Timeout (ALU_ARB_TIMEOUT_EN): no alu_done for 16 cycles.
  -> err_timeout=1, FSM IDLE, next requester granted.
REQ-024 Spurious done: alu_done pulsed in IDLE.
  -> no state change, no cdb_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter slice.
//   OP_W / DATA_W / TAG_W : default opcode, operand/result and tag widths.
//   state_t               : issue FSM states (IDLE, ISSUE, WAIT, BCAST).
package alu_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    BCAST
  } state_t;

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Bundle of the arbiter's requester, ALU and common-data-bus signals.
//   master : arbiter view (drives req_ack, alu_*, cdb_valid/tag/data, busy,
//            err_timeout).
//   slave  : environment view (requesters, ALU and CDB).
// Packed request vectors hold requester i in slice i.
interface alu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = alu_pkg::DATA_W,
  parameter int unsigned TAG_W   = alu_pkg::TAG_W,
  parameter int unsigned OP_W    = alu_pkg::OP_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*OP_W-1:0]   req_opcode;
  logic [NUM_REQ*DATA_W-1:0] req_op1;
  logic [NUM_REQ*DATA_W-1:0] req_op2;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_ack;

  logic                      alu_start;
  logic [OP_W-1:0]           alu_opcode;
  logic [DATA_W-1:0]         alu_op1;
  logic [DATA_W-1:0]         alu_op2;
  logic [TAG_W-1:0]          alu_dest_tag;
  logic                      alu_done;
  logic [TAG_W-1:0]          alu_out_tag;
  logic [DATA_W-1:0]         alu_result;

  logic                      cdb_valid;
  logic                      cdb_ready;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;

  logic                      busy;
  logic                      err_timeout;

  modport master (
    input  req_valid, req_opcode, req_op1, req_op2, req_tag,
    input  alu_done, alu_out_tag, alu_result, cdb_ready,
    output req_ack, alu_start, alu_opcode, alu_op1, alu_op2, alu_dest_tag,
    output cdb_valid, cdb_tag, cdb_data, busy, err_timeout
  );

  modport slave (
    output req_valid, req_opcode, req_op1, req_op2, req_tag,
    output alu_done, alu_out_tag, alu_result, cdb_ready,
    input  req_ack, alu_start, alu_opcode, alu_op1, alu_op2, alu_dest_tag,
    input  cdb_valid, cdb_tag, cdb_data, busy, err_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector.
//   ptr   : highest-priority index; search runs ptr, ptr+1, ... with wrap.
//   grant : one-hot winner (all zero when no request).
//   idx   : binary index of the winner (zero when no request).
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned pos;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of a single ALU with result broadcast on
// the common data bus.
//   clk, rst : clock (rising edge) and asynchronous active-high reset.
//   bus      : alu_issue_arbiter_if.master -- requester handshake, ALU launch
//              and completion, CDB broadcast, busy and err_timeout.
// Optional build macro ALU_ARB_TIMEOUT_EN adds a WAIT watchdog that sets the
// sticky err_timeout and abandons the operation after TIMEOUT_CYC cycles.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = alu_pkg::DATA_W,
  parameter int unsigned TAG_W       = alu_pkg::TAG_W,
  parameter int unsigned OP_W        = alu_pkg::OP_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic                 clk,
  input logic                 rst,
  alu_issue_arbiter_if.master bus
);

  import alu_pkg::state_t;
  import alu_pkg::IDLE;
  import alu_pkg::ISSUE;
  import alu_pkg::WAIT;
  import alu_pkg::BCAST;

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, g_idx, arb_idx;
  logic [NUM_REQ-1:0] arb_grant, ack_c;
  logic               start_c, cdb_valid_c;
  logic               take, capture, adv_ptr, wd_expire;

  logic [OP_W-1:0]    opcode_q;
  logic [DATA_W-1:0]  op1_q, op2_q, hold_data;
  logic [TAG_W-1:0]   tag_q, hold_tag;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Expires in the TIMEOUT_CYC-th consecutive WAIT cycle without alu_done.
  assign wd_expire = (state == WAIT) && !bus.alu_done &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (wd_expire) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wd_expire          = 1'b0;
  assign bus.err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Acceptance is combinational in IDLE so the launch lands one cycle after
  // the ack; rst gates it so reset forces req_ack low immediately.
  always_comb begin
    state_nxt   = state;
    ack_c       = '0;
    start_c     = 1'b0;
    cdb_valid_c = 1'b0;
    take        = 1'b0;
    capture     = 1'b0;
    adv_ptr     = 1'b0;
    case (state)
      IDLE: begin
        if ((|bus.req_valid) && !rst) begin
          ack_c     = arb_grant;
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start_c   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.alu_done) begin
          capture   = 1'b1;
          state_nxt = BCAST;
        end else if (wd_expire) begin
          adv_ptr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BCAST: begin
        cdb_valid_c = 1'b1;
        if (bus.cdb_ready) begin
          adv_ptr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      g_idx     <= '0;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      tag_q     <= '0;
      hold_tag  <= '0;
      hold_data <= '0;
    end else begin
      if (take) begin
        g_idx    <= arb_idx;
        opcode_q <= bus.req_opcode[arb_idx*OP_W +: OP_W];
        op1_q    <= bus.req_op1[arb_idx*DATA_W +: DATA_W];
        op2_q    <= bus.req_op2[arb_idx*DATA_W +: DATA_W];
        tag_q    <= bus.req_tag[arb_idx*TAG_W +: TAG_W];
      end
      if (capture) begin
        hold_tag  <= bus.alu_out_tag;
        hold_data <= bus.alu_result;
      end
      if (adv_ptr) begin
        rr_ptr <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
    end
  end

  assign bus.req_ack      = ack_c;
  assign bus.alu_start    = start_c;
  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_op1      = op1_q;
  assign bus.alu_op2      = op2_q;
  assign bus.alu_dest_tag = tag_q;
  assign bus.cdb_valid    = cdb_valid_c;
  assign bus.cdb_tag      = hold_tag;
  assign bus.cdb_data     = hold_data;
  assign bus.busy         = (state != IDLE);

endmodule
